// File: rtl/hdmi_src_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_src_scheduler_pkg
//  Description : Shared definitions for the HDMI source scheduler slice.
//                Contains the RGB width, common colour constants used by the
//                pattern generators and the bench, and the key debounce FSM
//                state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package hdmi_src_scheduler_pkg;

    localparam int RGB_W = 24;

    typedef logic [RGB_W-1:0] rgb_t;

    // RGB888 colour constants
    localparam rgb_t c_black = 24'h000000;
    localparam rgb_t c_white = 24'hFFFFFF;
    localparam rgb_t c_red   = 24'hFF0000;
    localparam rgb_t c_green = 24'h00FF00;
    localparam rgb_t c_blue  = 24'h0000FF;

    // Key debounce FSM state encodings
    localparam logic [1:0] c_db_released     = 2'd0;
    localparam logic [1:0] c_db_press_wait   = 2'd1;
    localparam logic [1:0] c_db_pressed      = 2'd2;
    localparam logic [1:0] c_db_release_wait = 2'd3;

endpackage
`default_nettype wire

// File: rtl/hdmi_src_scheduler_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer for an asynchronous active-low push
//                button followed by a four-state debounce FSM. A level is
//                accepted only after DEBOUNCE_CYC consecutive identical
//                samples; an accepted press produces a one-cycle press_evt.
//  Ports       : vga_clk   in  clock
//                rst_n     in  asynchronous active-low reset
//                key_n     in  raw button, active-low, asynchronous
//                press_evt out one-cycle strobe on an accepted press
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import hdmi_src_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_evt
);

    localparam int                 c_cnt_w    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYC - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press_evt;

    // The synchronizer resets to the released level so that a reset release
    // never looks like the start of a press.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_db_released;
            r_cnt       <= '0;
            r_press_evt <= 1'b0;
        end else begin
            r_press_evt <= 1'b0;
            case (r_state)
                c_db_released: begin
                    if (!r_sync2) begin
                        r_state <= c_db_press_wait;
                        r_cnt   <= '0;
                    end
                end
                c_db_press_wait: begin
                    if (r_sync2) begin
                        r_state <= c_db_released;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state     <= c_db_pressed;
                        r_cnt       <= '0;
                        r_press_evt <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_db_pressed: begin
                    if (r_sync2) begin
                        r_state <= c_db_release_wait;
                        r_cnt   <= '0;
                    end
                end
                c_db_release_wait: begin
                    if (!r_sync2) begin
                        r_state <= c_db_pressed;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= c_db_released;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state <= c_db_released;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign press_evt = r_press_evt;

endmodule
`default_nettype wire

// File: rtl/hdmi_src_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_src_scheduler
//  Description : Selects which of N_SRC pattern sources drives pix_data.
//                The selection only changes on a frame edge (active-going
//                vsync) so frames never tear. It advances on a debounced key
//                press or, with auto_en set, every FRAMES_PER_SRC frames.
//  Ports       : vga_clk      in  pixel clock (sole clock)
//                rst_n        in  asynchronous active-low reset
//                vsync        in  frame sync from the timing controller
//                key_n        in  raw push button, active-low
//                auto_en      in  timed auto-cycling enable
//                src_data     in  packed RGB888 sources, source k at [24k+:24]
//                pix_data     out selected RGB888 (1-cycle registered mux)
//                src_sel      out active source index
//                switch_pulse out 1-cycle strobe when src_sel changes
//  Revision    : 1.0  initial release
// ============================================================================
module hdmi_src_scheduler
    import hdmi_src_scheduler_pkg::*;
#(
    parameter int N_SRC          = 4,
    parameter int SEL_W          = 2,
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int FRAMES_PER_SRC = 120,
    parameter int VSYNC_POL      = 1
) (
    input  logic                     vga_clk,
    input  logic                     rst_n,
    input  logic                     vsync,
    input  logic                     key_n,
    input  logic                     auto_en,
    input  logic [N_SRC*RGB_W-1:0]   src_data,
    output logic [RGB_W-1:0]         pix_data,
    output logic [SEL_W-1:0]         src_sel,
    output logic                     switch_pulse
);

    localparam int                  c_fcnt_w    = $clog2(FRAMES_PER_SRC + 1);
    localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FRAMES_PER_SRC - 1);
    localparam logic [SEL_W-1:0]    c_sel_last  = SEL_W'(N_SRC - 1);

    logic                w_press_evt;
    logic                r_vs_d1;
    logic                r_vs_d2;
    logic                w_act_d1;
    logic                w_act_d2;
    logic                w_frame_edge;
    logic [c_fcnt_w-1:0] r_fcnt;
    logic                w_auto_hit;
    logic                w_advance;
    logic                r_pending;
    logic [SEL_W-1:0]    r_src_sel;
    logic                r_switch_pulse;
    logic [RGB_W-1:0]    w_pix;
    logic [RGB_W-1:0]    r_pix_data;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_debounce (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .key_n     (key_n),
        .press_evt (w_press_evt)
    );

    // vsync is registered once; the second flop only holds the previous
    // sample for edge detection, so frame_edge lands one cycle after the
    // first active vsync cycle.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d1 <= 1'b0;
            r_vs_d2 <= 1'b0;
        end else begin
            r_vs_d1 <= vsync;
            r_vs_d2 <= r_vs_d1;
        end
    end

    assign w_act_d1     = (VSYNC_POL != 0) ? r_vs_d1 : ~r_vs_d1;
    assign w_act_d2     = (VSYNC_POL != 0) ? r_vs_d2 : ~r_vs_d2;
    assign w_frame_edge = w_act_d1 & ~w_act_d2;

    assign w_auto_hit = auto_en & (r_fcnt == c_fcnt_last);
    assign w_advance  = w_frame_edge & (r_pending | w_auto_hit);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fcnt         <= '0;
            r_pending      <= 1'b0;
            r_src_sel      <= '0;
            r_switch_pulse <= 1'b0;
        end else begin
            if (!auto_en || w_advance) begin
                r_fcnt <= '0;
            end else if (w_frame_edge) begin
                r_fcnt <= r_fcnt + c_fcnt_w'(1);
            end

            // A press landing on the consuming edge wins, so it is carried
            // into the next frame rather than lost.
            if (w_press_evt) begin
                r_pending <= 1'b1;
            end else if (w_advance) begin
                r_pending <= 1'b0;
            end

            if (w_advance) begin
                r_src_sel <= (r_src_sel == c_sel_last) ? '0 : r_src_sel + SEL_W'(1);
            end

            r_switch_pulse <= w_advance;
        end
    end

    always_comb begin
        w_pix = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (r_src_sel == SEL_W'(k)) begin
                w_pix = src_data[k*RGB_W +: RGB_W];
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data <= '0;
        end else begin
            r_pix_data <= w_pix;
        end
    end

    assign pix_data     = r_pix_data;
    assign src_sel      = r_src_sel;
    assign switch_pulse = r_switch_pulse;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_src_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdmi_src_scheduler
//  Description : Self-checking bench for hdmi_src_scheduler. A frame-level
//                model predicts each source switch; predicted switches are
//                queued and a monitor checks them when switch_pulse appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hdmi_src_scheduler;
    import hdmi_src_scheduler_pkg::*;

    localparam int N_SRC = 4;
    localparam int SEL_W = 2;
    localparam int DEB   = 8;
    localparam int FPS   = 3;
    localparam int FRAME = 100;

    logic                   vga_clk = 1'b0;
    logic                   rst_n   = 1'b0;
    logic                   vsync   = 1'b0;
    logic                   key_n   = 1'b1;
    logic                   auto_en = 1'b0;
    logic [N_SRC*24-1:0]    src_data;
    logic [23:0]            pix_data;
    logic [SEL_W-1:0]       src_sel;
    logic                   switch_pulse;

    always #5 vga_clk = ~vga_clk;

    hdmi_src_scheduler #(
        .N_SRC          (N_SRC),
        .SEL_W          (SEL_W),
        .DEBOUNCE_CYC   (DEB),
        .FRAMES_PER_SRC (FPS),
        .VSYNC_POL      (1)
    ) dut (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .vsync        (vsync),
        .key_n        (key_n),
        .auto_en      (auto_en),
        .src_data     (src_data),
        .pix_data     (pix_data),
        .src_sel      (src_sel),
        .switch_pulse (switch_pulse)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] old_sel;
        logic [1:0] new_sel;
    } sw_t;

    sw_t exp_q[$];

    // Frame-level reference state
    int m_sel     = 0;
    int m_cnt     = 0;
    bit m_pending = 1'b0;

    function automatic logic [23:0] slice(input logic [N_SRC*24-1:0] d, input int i);
        return d[i*24 +: 24];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One frame edge: a pending press or an expired auto interval gives a
    // single advance; otherwise the frame count moves on while auto is on.
    task automatic model_edge();
        bit hit;
        int nxt;
        hit = auto_en && (m_cnt == FPS - 1);
        if (m_pending || hit) begin
            nxt = (m_sel + 1) % N_SRC;
            exp_q.push_back(sw_t'{old_sel: 2'(m_sel), new_sel: 2'(nxt)});
            m_sel     = nxt;
            m_cnt     = 0;
            m_pending = 1'b0;
        end else if (auto_en) begin
            m_cnt = m_cnt + 1;
        end else begin
            m_cnt = 0;
        end
    endtask

    // action: 0 idle, 1 press, 2 bounce, 3 toggle auto_en, 4 new src_data
    task automatic run_frame(input int action);
        int p_start;
        int b_start;
        p_start = $urandom_range(10, 60);
        b_start = $urandom_range(10, 40);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge vga_clk);
            vsync = (c < 4);
            key_n = 1'b1;
            if (c == 0) model_edge();
            if (action == 3 && c == 5) begin
                auto_en = ~auto_en;
                if (!auto_en) m_cnt = 0;
            end
            if (action == 1) begin
                if (c >= p_start && c < p_start + 20) key_n = 1'b0;
                if (c == p_start) m_pending = 1'b1;
            end
            if (action == 2 && c >= b_start && c < b_start + 40)
                key_n = (((c - b_start) / 3) % 2) == 0;
            if (action == 4 && c == 50)
                src_data = {$urandom(), $urandom(), $urandom()};
            if (c == 95) begin
                check("sel_midframe", 32'(src_sel), 32'(m_sel));
                check("pix_midframe", 32'(pix_data), 32'(slice(src_data, m_sel)));
                check("switch_queue_drained", 32'(exp_q.size()), 32'd0);
            end
        end
    endtask

    // Monitor: every switch_pulse must match the oldest predicted switch,
    // with pix_data following one cycle later.
    initial begin
        sw_t e;
        forever begin
            @(negedge vga_clk);
            if (rst_n && switch_pulse) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_switch actual=src_sel %0d required=no_pulse t=%0t", src_sel, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sel_on_pulse", 32'(src_sel), 32'(e.new_sel));
                    check("pix_on_pulse", 32'(pix_data), 32'(slice(src_data, int'(e.old_sel))));
                    @(negedge vga_clk);
                    check("pix_after_pulse", 32'(pix_data), 32'(slice(src_data, int'(e.new_sel))));
                    check("pulse_width", 32'(switch_pulse), 32'd0);
                end
            end
        end
    end

    initial begin
        int guard;
        src_data = {c_blue, c_green, c_red, c_white};
        rst_n    = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("reset_sel", 32'(src_sel), 32'd0);
        check("reset_pix", 32'(pix_data), 32'd0);
        check("reset_pulse", 32'(switch_pulse), 32'd0);
        rst_n = 1'b1;

        // Idle: source 0 (white) stays selected
        repeat (10) run_frame(0);
        check("idle_pix_white", 32'(pix_data), 32'(c_white));

        // Debounced press advances at the following frame edge
        run_frame(1);
        run_frame(0);
        check("press_sel1", 32'(src_sel), 32'd1);
        check("press_pix_red", 32'(pix_data), 32'(c_red));

        // Bounce is rejected
        run_frame(2);
        run_frame(0);
        check("bounce_sel_held", 32'(src_sel), 32'd1);

        // Auto cycling with wrap
        auto_en = 1'b1;
        repeat (12) run_frame(0);

        // Press debounced in the frame whose closing edge is an auto hit
        guard = 0;
        while (m_cnt != FPS - 2 && guard < 8) begin
            run_frame(0);
            guard++;
        end
        run_frame(1);
        repeat (4) run_frame(0);

        // Randomized mix
        repeat (30) run_frame($urandom_range(0, 4));

        // Reset mid-operation with src_sel=2 and a press pending
        auto_en = 1'b0;
        m_cnt   = 0;
        guard   = 0;
        while ((m_sel != 2 || !m_pending) && guard < 10) begin
            run_frame(1);
            guard++;
        end
        check("pre_reset_sel2", 32'(src_sel), 32'd2);
        @(negedge vga_clk);
        key_n = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_sel", 32'(src_sel), 32'd0);
        check("async_reset_pix", 32'(pix_data), 32'd0);
        repeat (3) @(negedge vga_clk);
        key_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        rst_n     = 1'b1;
        m_sel     = 0;
        m_cnt     = 0;
        m_pending = 1'b0;
        repeat (3) run_frame(0);
        check("post_reset_no_advance", 32'(src_sel), 32'd0);
        run_frame(1);
        run_frame(0);
        check("post_reset_press", 32'(src_sel), 32'd1);

        repeat (5) @(negedge vga_clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
